// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code constants, legality check and the
// arbiter FSM state encoding.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_EQ   = 4'b1001;
    localparam logic [3:0] OP_NEQ  = 4'b1010;
    localparam logic [3:0] OP_GE   = 4'b1100;
    localparam logic [3:0] OP_GEU  = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic op_is_legal(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL,
            OP_SRA, OP_OR, OP_AND, OP_EQ, OP_NEQ, OP_GE, OP_GEU: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant to the first valid
// requester searching upward from last_ptr+1 (mod N).
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     valid_i,
    input  logic [PTR_W-1:0] last_ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [PTR_W-1:0] grant_idx_o,
    output logic             any_o
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        sum         = '0;
        idx         = '0;
        for (int i = 1; i <= N; i++) begin
            sum = {1'b0, last_ptr_i} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(N)) begin
                sum = sum - (PTR_W+1)'(N);
            end
            idx = sum[PTR_W-1:0];
            if (!any_o && valid_i[idx]) begin
                any_o        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU among NREQ requesters; one
// operation in flight, IDLE -> EXEC -> RESP.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NREQ-1:0]   req_valid_i,
    output logic [NREQ-1:0]   req_ready_o,
    input  logic [NREQ*32-1:0] req_data1_i,
    input  logic [NREQ*32-1:0] req_data2_i,
    input  logic [NREQ*4-1:0] req_op_i,
    output logic [NREQ-1:0]   resp_valid_o,
    input  logic [NREQ-1:0]   resp_ready_i,
    output logic [31:0]       resp_result_o,
    output logic              resp_err_o,
    output logic [31:0]       alu_data1_o,
    output logic [31:0]       alu_data2_o,
    output logic [3:0]        alu_op_o,
    input  logic [31:0]       alu_result_i,
    output logic              busy_o
);

    state_e           state_q, state_d;
    logic [PTR_W-1:0] last_ptr_q, last_ptr_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [31:0]      data1_q, data1_d;
    logic [31:0]      data2_q, data2_d;
    logic [3:0]       op_q, op_d;
    logic [31:0]      result_q, result_d;
    logic             err_q, err_d;

    logic [NREQ-1:0]  grant;
    logic [PTR_W-1:0] grant_idx;
    logic             grant_any;

    rr_arbiter #(
        .N     (NREQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .valid_i     (req_valid_i),
        .last_ptr_i  (last_ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_o       (grant_any)
    );

    always_comb begin
        state_d      = state_q;
        last_ptr_d   = last_ptr_q;
        owner_d      = owner_q;
        data1_d      = data1_q;
        data2_d      = data2_q;
        op_d         = op_q;
        result_d     = result_q;
        err_d        = err_q;
        req_ready_o  = '0;
        resp_valid_o = '0;
        case (state_q)
            ST_IDLE: begin
                req_ready_o = grant;
                if (grant_any) begin
                    data1_d    = req_data1_i[32*int'(grant_idx) +: 32];
                    data2_d    = req_data2_i[32*int'(grant_idx) +: 32];
                    op_d       = req_op_i[4*int'(grant_idx) +: 4];
                    owner_d    = grant_idx;
                    last_ptr_d = grant_idx;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Illegal ops still complete, but return zero with the error flag.
                result_d = op_is_legal(op_q) ? alu_result_i : 32'd0;
                err_d    = !op_is_legal(op_q);
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                resp_valid_o[owner_q] = 1'b1;
                if (resp_ready_i[owner_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            last_ptr_q <= PTR_W'(NREQ-1);
            owner_q    <= '0;
            data1_q    <= '0;
            data2_q    <= '0;
            op_q       <= OP_ADD;
            result_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_ptr_q <= last_ptr_d;
            owner_q    <= owner_d;
            data1_q    <= data1_d;
            data2_q    <= data2_d;
            op_q       <= op_d;
            result_q   <= result_d;
            err_q      <= err_d;
        end
    end

    assign alu_data1_o   = data1_q;
    assign alu_data2_o   = data2_q;
    assign alu_op_o      = op_q;
    assign resp_result_o = result_q;
    assign resp_err_o    = err_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, hand-written
// backpressure/reset sequences and a randomized run against a reference model.
module tb_alu_arbiter;

    localparam int N = 2;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_d1;
    logic [N*32-1:0] req_d2;
    logic [N*4-1:0]  req_op;
    logic [N-1:0]    resp_valid;
    logic [N-1:0]    resp_ready;
    logic [31:0]     resp_result;
    logic            resp_err;
    logic [31:0]     alu_d1;
    logic [31:0]     alu_d2;
    logic [3:0]      alu_op;
    logic [31:0]     alu_result;
    logic            busy;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.NREQ(N)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_data1_i   (req_d1),
        .req_data2_i   (req_d2),
        .req_op_i      (req_op),
        .resp_valid_o  (resp_valid),
        .resp_ready_i  (resp_ready),
        .resp_result_o (resp_result),
        .resp_err_o    (resp_err),
        .alu_data1_o   (alu_d1),
        .alu_data2_o   (alu_d2),
        .alu_op_o      (alu_op),
        .alu_result_i  (alu_result),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU environment; returns garbage for illegal codes so forcing is visible.
    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0001: return a << b[4:0];
            4'b0010: return {31'd0, $signed(a) < $signed(b)};
            4'b0011: return {31'd0, a < b};
            4'b0100: return a ^ b;
            4'b0101: return a >> b[4:0];
            4'b1101: return $unsigned($signed(a) >>> b[4:0]);
            4'b0110: return a | b;
            4'b0111: return a & b;
            4'b1001: return {31'd0, a == b};
            4'b1010: return {31'd0, a != b};
            4'b1100: return {31'd0, $signed(a) >= $signed(b)};
            4'b1011: return {31'd0, a >= b};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign alu_result = alu_f(alu_op, alu_d1, alu_d2);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid[k]       = 1'b1;
        req_op[4*k +: 4]   = op;
        req_d1[32*k +: 32] = a;
        req_d2[32*k +: 32] = b;
    endtask

    function automatic logic [N-1:0] oh(input int k);
        logic [N-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    typedef struct {
        int          req;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic        exp_err;
    } vec_t;

    // Reference model state: one held operation per requester, rotating priority.
    logic [N-1:0] pend;
    logic [3:0]   pop [N];
    logic [31:0]  pa  [N];
    logic [31:0]  pb  [N];
    int           mlast;
    bit           inflight;
    int           cnt;
    int           mowner;
    logic [31:0]  exp_res;
    logic         exp_err;

    task automatic run_model(input int ncycles, input int prob, input bit only_add,
                             input bit always_ready, input bit check_period);
        int prev_xfer;
        int g;
        int idx;
        prev_xfer = -1;
        for (int c = 0; c < ncycles; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!pend[k] && ($urandom % 100) < prob) begin
                    pend[k] = 1'b1;
                    pop[k]  = only_add ? 4'b0000 : 4'($urandom % 16);
                    pa[k]   = $urandom;
                    pb[k]   = $urandom;
                end
                req_valid[k] = pend[k];
                if (pend[k]) set_req(k, pop[k], pa[k], pb[k]);
            end
            resp_ready = always_ready ? '1 : N'($urandom);
            #1;
            if (!inflight) begin
                g = -1;
                for (int i = 1; i <= N; i++) begin
                    idx = (mlast + i) % N;
                    if (g < 0 && pend[idx]) g = idx;
                end
                chk("model_grant", 64'(req_ready), (g >= 0) ? 64'(oh(g)) : 64'd0);
                chk("model_idle_busy", 64'(busy), 64'd0);
                if (g >= 0) begin
                    inflight = 1'b1;
                    cnt      = 0;
                    mowner   = g;
                    exp_err  = (pop[g][3:1] == 3'b111);
                    exp_res  = exp_err ? 32'd0 : alu_f(pop[g], pa[g], pb[g]);
                    mlast    = g;
                    pend[g]  = 1'b0;
                end
            end else begin
                cnt++;
                if (cnt == 1) begin
                    chk("model_exec", {62'd0, busy, |(req_ready | resp_valid)}, 64'd2);
                end else begin
                    chk("model_resp_valid", 64'(resp_valid), 64'(oh(mowner)));
                    chk("model_result", {31'd0, resp_err, resp_result}, {31'd0, exp_err, exp_res});
                    chk("model_resp_noready", 64'(req_ready), 64'd0);
                    if (resp_ready[mowner]) begin
                        inflight = 1'b0;
                        if (check_period && prev_xfer >= 0) chk("model_period", 64'(c - prev_xfer), 64'd3);
                        prev_xfer = c;
                    end
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    vec_t vecs [6];

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_d1     = '0;
        req_d2     = '0;
        req_op     = '0;
        resp_ready = '0;
        pend       = '0;
        inflight   = 1'b0;
        cnt        = 0;
        mowner     = 0;
        mlast      = N - 1;
        exp_res    = '0;
        exp_err    = 1'b0;
        for (int k = 0; k < N; k++) begin
            pop[k] = '0;
            pa[k]  = '0;
            pb[k]  = '0;
        end

        vecs[0] = '{0, 4'b0000, 32'd5,          32'd7,  32'd12,         1'b0};
        vecs[1] = '{1, 4'b1000, 32'd3,          32'd5,  32'hFFFFFFFE,   1'b0};
        vecs[2] = '{1, 4'b0011, 32'd1,          32'd2,  32'd1,          1'b0};
        vecs[3] = '{1, 4'b1101, 32'h80000000,   32'd4,  32'hF8000000,   1'b0};
        vecs[4] = '{0, 4'b1110, 32'd9,          32'd9,  32'd0,          1'b1};
        vecs[5] = '{0, 4'b0100, 32'hFF,         32'h0F, 32'hF0,         1'b0};

        #12;
        chk("reset_ctrl", {60'd0, req_ready, resp_valid}, 64'd0);
        chk("reset_flags", {62'd0, resp_err, busy}, 64'd0);
        chk("reset_result", 64'(resp_result), 64'd0);
        chk("reset_alu", {alu_op, 28'd0, alu_d1 | alu_d2}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) begin
            set_req(vecs[v].req, vecs[v].op, vecs[v].a, vecs[v].b);
            #1;
            chk("vec_grant", 64'(req_ready), 64'(oh(vecs[v].req)));
            tick();
            req_valid = '0;
            chk("vec_exec_ready", 64'(req_ready), 64'd0);
            chk("vec_exec_busy", 64'(busy), 64'd1);
            chk("vec_alu_regs", {alu_op, 28'd0, alu_d1}, {vecs[v].op, 28'd0, vecs[v].a});
            tick();
            chk("vec_resp_valid", 64'(resp_valid), 64'(oh(vecs[v].req)));
            chk("vec_result", 64'(resp_result), 64'(vecs[v].exp_res));
            chk("vec_err", 64'(resp_err), 64'(vecs[v].exp_err));
            resp_ready = oh(vecs[v].req);
            tick();
            resp_ready = '0;
            chk("vec_back_idle", {62'd0, busy, |resp_valid}, 64'd0);
        end

        // Backpressure: owner holds off for 5 cycles, non-owner ready is ignored.
        set_req(0, 4'b0000, 32'd10, 32'd20);
        tick();
        req_valid = '0;
        tick();
        set_req(1, 4'b1000, 32'd9, 32'd4);
        resp_ready = 2'b10;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_resp_valid", 64'(resp_valid), 64'd1);
            chk("bp_result", {31'd0, resp_err, resp_result}, 64'd30);
            chk("bp_no_grant", {62'd0, req_ready}, 64'd0);
            chk("bp_busy", 64'(busy), 64'd1);
            tick();
        end
        resp_ready = 2'b01;
        tick();
        resp_ready = '0;
        #1;
        chk("bp_next_grant", 64'(req_ready), 64'd2);
        tick();
        req_valid = '0;
        tick();
        chk("bp_req1_result", {31'd0, resp_err, resp_result}, 64'd5);
        resp_ready = 2'b10;
        tick();
        resp_ready = '0;

        // Reset mid-EXEC after requester 0 won; priority must restart at requester 0.
        set_req(0, 4'b0000, 32'd1, 32'd1);
        tick();
        req_valid = '0;
        rst = 1'b1;
        #1;
        chk("rst_exec_ctrl", {58'd0, busy, resp_err, req_ready, resp_valid}, 64'd0);
        chk("rst_exec_result", 64'(resp_result), 64'd0);
        chk("rst_exec_alu", {alu_op, 28'd0, alu_d1 | alu_d2}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("rst_no_resp", 64'(resp_valid), 64'd0);
        set_req(0, 4'b0000, 32'd2, 32'd3);
        set_req(1, 4'b0000, 32'd4, 32'd4);
        #1;
        chk("rst_priority", 64'(req_ready), 64'd1);
        tick();
        req_valid[0] = 1'b0;
        tick();
        chk("rst_op_result", {resp_valid, 31'd0, resp_err, resp_result}, {2'b01, 31'd0, 1'b0, 32'd5});
        resp_ready = '1;
        tick();
        resp_ready = '0;
        #1;
        chk("rst_second_grant", 64'(req_ready), 64'd2);
        tick();
        req_valid = '0;
        tick();
        chk("rst_second_result", 64'(resp_result), 64'd8);
        resp_ready = '1;
        tick();
        resp_ready = '0;

        // Randomized phases against the model; requester 1 was granted last.
        mlast = 1;
        run_model(30, 100, 1'b1, 1'b1, 1'b1);
        run_model(20, 0, 1'b0, 1'b1, 1'b0);
        run_model(400, 40, 1'b0, 1'b0, 1'b0);
        run_model(30, 0, 1'b0, 1'b1, 1'b0);
        chk("final_idle", {62'd0, busy, |pend}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
